skeeball_game_ctrl: RTL and testbench
=====================================

// Module: skeeball_game_ctrl
// PURPOSE
//  Game sequencer in front of the skeeball BCD score accumulator.
//  - Synchronises and debounces the seven raw hole sensors.
//  - Turns each sensor rising edge into a single-cycle, one-hot hit pulse for the scorer.
//  - Counts balls and drives playstate (scorer clears its score while playstate is low).
//  - Ends the game on last ball or inactivity timeout; the final score stays displayed.
// PARAMETERS
//  NUM_BALLS        9        balls per game (1..15)
//  DEBOUNCE_CYCLES  4        consecutive synced-high samples before a hit counts (1..255)
//  TIMEOUT_CYCLES   1000000  cycles in PLAY with no emitted hit before forced game over
// PORTS
//  clk         in   1  single clock; all state changes on posedge clk
//  rst         in   1  asynchronous, active-high reset
//  start       in   1  start button, async level; its synced rising edge starts a game
//  hole        in   7  raw sensors, async; [6]=100,[5]=50,[4]=40,[3]=30,[2]=20,[1]=10,[0]=0/gutter
//  playstate   out  1  to scorer playstate
//  hit         out  7  one-hot hit pulse to scorer in100..in0, same bit order as hole
//  balls_left  out  4  balls remaining in the current game
//  game_over   out  1  high in OVER
// BEHAVIOUR
//  Reset: state=IDLE; playstate=0, hit=0, balls_left=0, game_over=0.
//   Synchronisers, debounce counters, pending bits and timer are cleared.
//   Reset asserted mid-game aborts the game immediately.
//  Input path, per hole:
//   - 2-flop synchroniser, then an 8-bit saturating counter of consecutive high samples.
//   - The counter resets on any low sample.
//   - The debounced level rises when the counter reaches DEBOUNCE_CYCLES.
//   - That rising edge sets the hole's pending bit.
//   - The debounced level falls on the first low sample.
//   - A ball held in a hole gives exactly one hit.
//   - start uses the same 2-flop sync plus an edge detect; start is not debounced.
//  Arbiter:
//   - In PLAY, each cycle: if any pending bit is set, hit = highest-value pending bit.
//   - That bit clears on the same edge that registers hit.
//   - At most one bit of hit is set in any cycle.
//   - Uncontended latency: raw rise first sampled at edge t gives hit high in cycle t+DEBOUNCE_CYCLES+3.
//   - Simultaneous holes are emitted on consecutive cycles in descending value.
//   - A hole re-triggering while its pending bit is still set is merged, not counted twice.
//  FSM (playstate / game_over per state):
//   IDLE  (0/0): synced start edge -> CLEAR.
//   CLEAR (0/0): exactly one cycle. balls_left=NUM_BALLS, pending=0, timer=0 -> PLAY.
//   PLAY  (1/0): each emitted hit decrements balls_left and zeroes the timer.
//     - Hit that takes balls_left to 0 -> OVER on the next edge.
//     - Timer reaching TIMEOUT_CYCLES-1 with no hit -> OVER.
//     - start edges are ignored.
//   OVER  (1/1): hit=0. playstate stays 1 so the score holds.
//     - Pending bits are cleared and new sensor edges are discarded.
//     - synced start edge -> CLEAR.
//  Arithmetic: balls_left never wraps and never decrements below 0.
//   Pending hits left when the last ball is emitted are discarded.
//   A pending edge and a start edge in the same cycle in OVER: start wins, pending is discarded.
//  All outputs are registered. hit is 0 in every state except PLAY.
// TESTING
//  1 Reset, then start edge -> playstate 0 for exactly 1 cycle (CLEAR), then 1; balls_left=9.
//  2 hole[5] high for 10 cycles from edge t -> hit=7'b0100000 only in cycle t+7; balls_left 9->8.
//  3 hole[6] and hole[2] rise in the same cycle t -> hit=7'b1000000 @t+7, 7'b0000100 @t+8; balls_left -2.
//  4 hole[3] high for 3 cycles only (debounce 4) -> hit stays 0; balls_left unchanged.
//  5 Nine hits -> OVER, game_over=1, playstate=1; tenth hole pulse -> no hit; start -> CLEAR -> PLAY, balls_left=9.
//  6 TIMEOUT_CYCLES=100, no hits after a start -> game_over=1 exactly 100 cycles after PLAY entry.
//    rst pulse during PLAY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/skeeball_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// skeeball_game_ctrl_if
// Bundles the sensor/button inputs and the scorer-facing outputs of the
// skeeball game sequencer.
//   master : the cabinet side (drives start/hole, observes outputs)
//   slave  : the game controller (consumes start/hole, drives outputs)
// Signals:
//   start      async start button level
//   hole[6:0]  async raw hole sensors, [6]=100 ... [0]=gutter
//   playstate  scorer playstate (score cleared while low)
//   hit[6:0]   one-hot single-cycle hit pulse, same bit order as hole
//   balls_left balls remaining in the current game
//   game_over  high while the game is over and the final score is shown
//   dbg_state  current controller state (0 IDLE, 1 CLEAR, 2 PLAY, 3 OVER)
// Handshake: there is no valid/ready pair. hit is a fire-and-forget pulse;
// the scorer must accept one hit per cycle with no backpressure.
// ---------------------------------------------------------------------------
interface skeeball_game_ctrl_if;
  logic       start;
  logic [6:0] hole;
  logic       playstate;
  logic [6:0] hit;
  logic [3:0] balls_left;
  logic       game_over;
  logic [1:0] dbg_state;

  modport master (
    output start, hole,
    input  playstate, hit, balls_left, game_over, dbg_state
  );

  modport slave (
    input  start, hole,
    output playstate, hit, balls_left, game_over, dbg_state
  );
endinterface

// File: rtl/skeeball_game_ctrl.sv
// ---------------------------------------------------------------------------
// skeeball_game_ctrl
// Game sequencer in front of the skeeball BCD score accumulator.
// Synchronises and debounces the hole sensors, turns each debounced rise
// into a one-hot hit pulse, counts balls, and ends the game on the last
// ball or on inactivity timeout.
// Ports:
//   clk  single clock, all state changes on posedge
//   rst  asynchronous active-high reset
//   bus  skeeball_game_ctrl_if.slave (start, hole in; playstate, hit,
//        balls_left, game_over, dbg_state out)
// ---------------------------------------------------------------------------
module skeeball_game_ctrl #(
  parameter int NUM_BALLS       = 9,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  skeeball_game_ctrl_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]    DEB      = 8'(DEBOUNCE_CYCLES);
  localparam logic [3:0]    NB       = 4'(NUM_BALLS);
  localparam logic [TW-1:0] TIME_MAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t        r_state;
  logic [6:0]    r_hole_s1, r_hole_s2;
  logic [7:0]    r_cnt [7];
  logic [6:0]    r_deb_q;
  logic [6:0]    r_pend;
  logic [6:0]    r_hit;
  logic [3:0]    r_balls;
  logic [TW-1:0] r_timer;
  logic          r_playstate, r_game_over;
  logic          r_start_s1, r_start_s2, r_start_s3;

  logic [6:0]    w_deb, w_rise, w_grant;
  logic          w_start_edge;

  // Input path: 2-flop sync, then a saturating run-length counter per hole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hole_s1  <= '0;
      r_hole_s2  <= '0;
      r_deb_q    <= '0;
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_s3 <= 1'b0;
      for (int i = 0; i < 7; i++) r_cnt[i] <= '0;
    end else begin
      r_hole_s1  <= bus.hole;
      r_hole_s2  <= r_hole_s1;
      r_deb_q    <= w_deb;
      r_start_s1 <= bus.start;
      r_start_s2 <= r_start_s1;
      r_start_s3 <= r_start_s2;
      for (int i = 0; i < 7; i++) begin
        if (!r_hole_s2[i])           r_cnt[i] <= '0;
        else if (r_cnt[i] != 8'hFF)  r_cnt[i] <= r_cnt[i] + 8'd1;
      end
    end
  end

  // Debounced level follows the counter directly, so it drops on the first
  // low sample; a ball parked in a hole keeps it high and yields one rise.
  always_comb begin
    w_deb = '0;
    for (int i = 0; i < 7; i++) w_deb[i] = (r_cnt[i] >= DEB);
  end

  assign w_rise       = w_deb & ~r_deb_q;
  assign w_start_edge = r_start_s2 & ~r_start_s3;

  // Highest-value pending hole wins; later iterations override earlier.
  always_comb begin
    w_grant = '0;
    for (int i = 0; i < 7; i++) begin
      if (r_pend[i]) begin
        w_grant    = '0;
        w_grant[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_hit       <= '0;
      r_balls     <= '0;
      r_timer     <= '0;
      r_playstate <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_hit <= '0;
      case (r_state)
        S_IDLE: begin
          r_pend <= '0;
          if (w_start_edge) r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          r_balls     <= NB;
          r_pend      <= '0;
          r_timer     <= '0;
          r_playstate <= 1'b1;
          r_game_over <= 1'b0;
          r_state     <= S_PLAY;
        end
        S_PLAY: begin
          if (r_balls == 4'd0) begin
            // Last ball was emitted on the previous edge; leftovers are dropped.
            r_pend      <= '0;
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else if (|r_pend) begin
            r_hit   <= w_grant;
            r_pend  <= (r_pend & ~w_grant) | w_rise;
            r_balls <= r_balls - 4'd1;
            r_timer <= '0;
          end else if (r_timer == TIME_MAX) begin
            r_pend      <= '0;
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else begin
            r_pend  <= w_rise;
            r_timer <= r_timer + TW'(1);
          end
        end
        S_OVER: begin
          // playstate stays high so the scorer keeps the final score.
          r_pend <= '0;
          if (w_start_edge) begin
            r_playstate <= 1'b0;
            r_game_over <= 1'b0;
            r_state     <= S_CLEAR;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.playstate  = r_playstate;
  assign bus.hit        = r_hit;
  assign bus.balls_left = r_balls;
  assign bus.game_over  = r_game_over;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_skeeball_game_ctrl.sv
module tb_skeeball_game_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  skeeball_game_ctrl_if bus_a ();
  skeeball_game_ctrl_if bus_b ();

  skeeball_game_ctrl #(
    .NUM_BALLS(9), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1000000)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  skeeball_game_ctrl #(
    .NUM_BALLS(9), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs_a(input string tag, input logic [6:0] e_hit,
                            input logic [3:0] e_balls, input logic e_play,
                            input logic e_over);
    chk({tag, ".hit"},       32'(bus_a.hit),        32'(e_hit));
    chk({tag, ".balls"},     32'(bus_a.balls_left), 32'(e_balls));
    chk({tag, ".playstate"}, 32'(bus_a.playstate),  32'(e_play));
    chk({tag, ".game_over"}, 32'(bus_a.game_over),  32'(e_over));
  endtask

  // Start edge: synced after 2 edges, CLEAR on the 3rd, PLAY on the 4th.
  task automatic start_game_a(input logic [3:0] prev_balls, input logic prev_over);
    bus_a.start = 1'b1;
    tick();
    tick();
    chk("start.pre_clear.state", 32'(bus_a.dbg_state), 32'd3 * 32'(prev_over));
    tick();
    chk("start.clear.state", 32'(bus_a.dbg_state), 32'd1);
    chk_outs_a("start.clear", 7'd0, prev_balls, 1'b0, 1'b0);
    tick();
    chk("start.play.state", 32'(bus_a.dbg_state), 32'd2);
    chk_outs_a("start.play", 7'd0, 4'd9, 1'b1, 1'b0);
    bus_a.start = 1'b0;
  endtask

  // Hold a pattern on the holes for hold_cyc samples and check hit over
  // 12 cycles. Expected hits land at tick 8 (first) and tick 9 (second).
  task automatic pulse_a(input string tag, input logic [6:0] pat, input int hold_cyc,
                         input logic [6:0] e1, input logic [6:0] e2,
                         input logic [3:0] b0, input logic last);
    logic [6:0] e_hit;
    logic [3:0] e_balls;
    logic       e_over;
    bus_a.hole = pat;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == hold_cyc) bus_a.hole = 7'd0;
      e_hit   = (n == 8) ? e1 : ((n == 9) ? e2 : 7'd0);
      e_balls = b0;
      if (n >= 8 && e1 != 7'd0) e_balls = e_balls - 4'd1;
      if (n >= 9 && e2 != 7'd0) e_balls = e_balls - 4'd1;
      e_over  = (last && n >= 9) || (b0 == 4'd0);
      chk_outs_a(tag, e_hit, e_balls, 1'b1, e_over);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_a.hole  = 7'd0;
    bus_b.start = 1'b0;
    bus_b.hole  = 7'd0;
    tick();
    tick();
    chk_outs_a("reset", 7'd0, 4'd0, 1'b0, 1'b0);
    chk("reset.state", 32'(bus_a.dbg_state), 32'd0);
    rst = 1'b0;
    tick();
    chk_outs_a("idle", 7'd0, 4'd0, 1'b0, 1'b0);

    // 1: start -> one CLEAR cycle -> PLAY with 9 balls
    start_game_a(4'd0, 1'b0);

    // 2: hole[5] held 10 cycles -> single hit at t+7
    pulse_a("t2_h5", 7'b0100000, 10, 7'b0100000, 7'b0000000, 4'd9, 1'b0);

    // 3: hole[6] and hole[2] together -> 100 then 20
    pulse_a("t3_h62", 7'b1000100, 10, 7'b1000000, 7'b0000100, 4'd8, 1'b0);

    // 4: hole[3] only 3 samples -> filtered
    pulse_a("t4_short", 7'b0001000, 3, 7'b0000000, 7'b0000000, 4'd6, 1'b0);

    // 5: six more hits finish the game
    pulse_a("t5_h0", 7'b0000001, 5, 7'b0000001, 7'b0000000, 4'd6, 1'b0);
    pulse_a("t5_h1", 7'b0000010, 5, 7'b0000010, 7'b0000000, 4'd5, 1'b0);
    pulse_a("t5_h4", 7'b0010000, 5, 7'b0010000, 7'b0000000, 4'd4, 1'b0);
    pulse_a("t5_h6", 7'b1000000, 5, 7'b1000000, 7'b0000000, 4'd3, 1'b0);
    pulse_a("t5_h3", 7'b0001000, 5, 7'b0001000, 7'b0000000, 4'd2, 1'b0);
    pulse_a("t5_h2", 7'b0000100, 5, 7'b0000100, 7'b0000000, 4'd1, 1'b1);
    chk("t5.over.state", 32'(bus_a.dbg_state), 32'd3);
    // tenth ball in OVER: discarded
    pulse_a("t5_tenth", 7'b1000000, 5, 7'b0000000, 7'b0000000, 4'd0, 1'b0);
    // restart from OVER
    start_game_a(4'd0, 1'b1);

    // 6: timeout on dut_b (100 cycles), no hits
    bus_b.start = 1'b1;
    for (int n = 1; n <= 4; n++) tick();
    bus_b.start = 1'b0;
    chk("t6.play.state", 32'(bus_b.dbg_state), 32'd2);
    chk("t6.play.playstate", 32'(bus_b.playstate), 32'd1);
    for (int n = 1; n <= 102; n++) begin
      tick();
      chk("t6.game_over", 32'(bus_b.game_over), (n >= 100) ? 32'd1 : 32'd0);
      chk("t6.playstate", 32'(bus_b.playstate), 32'd1);
    end
    chk("t6.balls", 32'(bus_b.balls_left), 32'd9);

    // async reset in the middle of a cycle while dut_a is in PLAY
    #2;
    rst = 1'b1;
    #1;
    chk_outs_a("async_rst", 7'd0, 4'd0, 1'b0, 1'b0);
    chk("async_rst.state", 32'(bus_a.dbg_state), 32'd0);
    chk("async_rst.b_over", 32'(bus_b.game_over), 32'd0);
    chk("async_rst.b_play", 32'(bus_b.playstate), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
